// File: rtl/gb_pool_reader_if.sv
// Signal bundle for gb_pool_reader: config handshake, GB PSUM pool port and activation stream.
// master = the reader, slave = its surroundings (GB, config source, downstream consumer).
interface gb_pool_reader_if #(
    parameter int NUM_PEB    = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ACT_WIDTH  = 8
);
    logic                          cfg_val;
    logic                          cfg_rdy;
    logic [ADDR_WIDTH-1:0]         cfg_num_addr;
    logic [4:0]                    cfg_shift;
    logic                          cfg_relu;
    logic                          cfg_pool_en;
    logic [ADDR_WIDTH-1:0]         POOLGB_addr;
    logic                          POOLGB_rdy;
    logic                          GBPOOL_val;
    logic [PSUM_WIDTH*NUM_PEB-1:0] GBPOOL_data;
    logic                          POOLGB_fnh;
    logic                          out_val;
    logic                          out_rdy;
    logic [ACT_WIDTH*NUM_PEB-1:0]  out_data;
    logic                          out_last;
    logic                          done;

    modport master (
        input  cfg_val, cfg_num_addr, cfg_shift, cfg_relu, cfg_pool_en,
        input  GBPOOL_val, GBPOOL_data, out_rdy,
        output cfg_rdy, POOLGB_addr, POOLGB_rdy, POOLGB_fnh,
        output out_val, out_data, out_last, done
    );

    modport slave (
        output cfg_val, cfg_num_addr, cfg_shift, cfg_relu, cfg_pool_en,
        output GBPOOL_val, GBPOOL_data, out_rdy,
        input  cfg_rdy, POOLGB_addr, POOLGB_rdy, POOLGB_fnh,
        input  out_val, out_data, out_last, done
    );
endinterface

// File: rtl/gb_pool_reader.sv
// Reads PSUM words 0..N-1 from the GB pool port, applies ReLU / rounded shift / saturation
// per lane, optionally 2:1 max-pools address pairs, and streams packed activations out.

module gb_pool_lane #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACT_WIDTH  = 8
) (
    input  logic signed [PSUM_WIDTH-1:0] psum,
    input  logic                         relu,
    input  logic [4:0]                   shift,
    input  logic signed [ACT_WIDTH-1:0]  hold,
    input  logic                         use_max,
    output logic signed [ACT_WIDTH-1:0]  q,
    output logic signed [ACT_WIDTH-1:0]  res
);
    // One guard bit so x + rounding constant can never wrap.
    localparam int W = PSUM_WIDTH + 1;
    localparam logic signed [W-1:0] ACT_MAX = W'((2 ** (ACT_WIDTH - 1)) - 1);
    localparam logic signed [W-1:0] ACT_MIN = ~ACT_MAX;

    logic signed [W-1:0] x, rnd, y;

    always_comb begin
        x   = (relu && psum[PSUM_WIDTH-1]) ? '0 : {psum[PSUM_WIDTH-1], psum};
        rnd = (shift == 5'd0) ? '0 : (W'(1) << (shift - 5'd1));
        y   = (x + rnd) >>> shift;
        if (y > ACT_MAX)      q = ACT_MAX[ACT_WIDTH-1:0];
        else if (y < ACT_MIN) q = ACT_MIN[ACT_WIDTH-1:0];
        else                  q = y[ACT_WIDTH-1:0];
        res = (use_max && (hold > q)) ? hold : q;
    end
endmodule

module gb_pool_reader #(
    parameter int NUM_PEB    = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ACT_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gb_pool_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FNH, DRAIN} state_t;

    state_t                            state;
    logic [ADDR_WIDTH-1:0]             addr, num_addr;
    logic [4:0]                        shift;
    logic                              relu, pool_en, phase;
    logic                              cfg_rdy_q, fnh_q, out_val_q, out_last_q;
    logic [NUM_PEB-1:0][PSUM_WIDTH-1:0] psum;
    logic [NUM_PEB-1:0][ACT_WIDTH-1:0]  q, res, hold, out_data_q;
    logic                              cfg_acc, pool_rdy, beat, last_beat, produce, drained;

    assign psum      = bus.GBPOOL_data;
    assign cfg_acc   = (state == IDLE) && bus.cfg_val;
    // A stalled output register blocks new PSUM beats; it frees up on the same cycle it drains.
    assign pool_rdy  = (state == FETCH) && (!out_val_q || bus.out_rdy);
    assign beat      = pool_rdy && bus.GBPOOL_val;
    assign last_beat = beat && (addr == num_addr - ADDR_WIDTH'(1));
    assign produce   = beat && (!pool_en || phase || last_beat);
    assign drained   = !out_val_q || bus.out_rdy;

    assign bus.cfg_rdy     = cfg_rdy_q;
    assign bus.POOLGB_addr = addr;
    assign bus.POOLGB_rdy  = pool_rdy;
    assign bus.POOLGB_fnh  = fnh_q;
    assign bus.out_val     = out_val_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.done        = (state == DRAIN) && drained;

    for (genvar i = 0; i < NUM_PEB; i++) begin : g_lane
        gb_pool_lane #(.PSUM_WIDTH(PSUM_WIDTH), .ACT_WIDTH(ACT_WIDTH)) u_lane (
            .psum    (psum[i]),
            .relu    (relu),
            .shift   (shift),
            .hold    (hold[i]),
            .use_max (pool_en && phase),
            .q       (q[i]),
            .res     (res[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            num_addr  <= '0;
            shift     <= '0;
            relu      <= 1'b0;
            pool_en   <= 1'b0;
            cfg_rdy_q <= 1'b1;
            fnh_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.cfg_val) begin
                    num_addr  <= bus.cfg_num_addr;
                    shift     <= bus.cfg_shift;
                    relu      <= bus.cfg_relu;
                    pool_en   <= bus.cfg_pool_en;
                    addr      <= '0;
                    cfg_rdy_q <= 1'b0;
                    if (bus.cfg_num_addr == '0) begin
                        state <= FNH;
                        fnh_q <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                FETCH: if (beat) begin
                    addr <= addr + ADDR_WIDTH'(1);
                    if (last_beat) begin
                        state <= FNH;
                        fnh_q <= 1'b1;
                    end
                end
                FNH: begin
                    fnh_q <= 1'b0;
                    state <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state     <= IDLE;
                    cfg_rdy_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            hold       <= '0;
            out_val_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (cfg_acc) begin
                phase <= 1'b0;
            end else if (beat && pool_en) begin
                // An odd trailing beat is emitted alone, so it never opens a pair.
                if (!phase && !last_beat) begin
                    hold  <= q;
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                end
            end
            if (produce) begin
                out_data_q <= res;
                out_val_q  <= 1'b1;
                out_last_q <= last_beat;
            end else if (out_val_q && bus.out_rdy) begin
                out_val_q  <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end
endmodule
